// File: rtl/frame_config_pkg.sv
// Shared definitions for the frame configuration sequencer: header layout,
// sync marker and the sequencer state encoding.
package frame_config_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFA;

    localparam int SYNC_MSB  = 31;
    localparam int SYNC_LSB  = 24;
    localparam int COL_MSB   = 23;
    localparam int COL_LSB   = 16;
    localparam int FRAME_MSB = 15;
    localparam int FRAME_LSB = 8;
    localparam int COUNT_MSB = 7;
    localparam int COUNT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        SETUP,
        STROBE,
        HOLD
    } seq_state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational index-to-one-hot decoder; an out-of-range index or a low
// enable yields an all-zero vector.
module frame_strobe_decoder #(
    parameter int Width      = 8,
    parameter int IndexWidth = 8
) (
    input  logic                  en,
    input  logic [IndexWidth-1:0] idx,
    output logic [Width-1:0]      hot
);

    always_comb begin
        hot = '0;
        for (int i = 0; i < Width; i++) begin
            if (en && (idx == IndexWidth'(i))) begin
                hot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// Streams header + data words into tile configuration frames, producing a
// one-cycle frame/column strobe with FrameData stable on both sides of it.
module frame_config_sequencer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [31:0]                s_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NumColumns-1:0]      ColSelect,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    import frame_config_pkg::*;

    seq_state_e state;
    logic [7:0] frameIndex;
    logic [7:0] remaining;
    logic [7:0] colIndex;

    logic [7:0] hdrSync;
    logic [7:0] hdrCol;
    logic [7:0] hdrFrame;
    logic [7:0] hdrCount;
    logic [8:0] endFrame;
    logic       headerBad;

    logic [FrameBitsPerRow-1:0] dataWord;
    logic [MaxFramesPerCol-1:0] frameHot;
    logic [NumColumns-1:0]      colHot;

    assign hdrSync  = s_data[SYNC_MSB:SYNC_LSB];
    assign hdrCol   = s_data[COL_MSB:COL_LSB];
    assign hdrFrame = s_data[FRAME_MSB:FRAME_LSB];
    assign hdrCount = s_data[COUNT_MSB:COUNT_LSB];

    // Nine-bit sum so a large start frame plus count cannot wrap into range
    assign endFrame  = {1'b0, hdrFrame} + {1'b0, hdrCount};
    assign headerBad = (hdrSync != SYNC_BYTE)
                    || (32'(hdrCol) >= NumColumns)
                    || (hdrCount == 8'd0)
                    || (32'(endFrame) > MaxFramesPerCol);

    generate
        if (FrameBitsPerRow > 32) begin : g_wide
            assign dataWord = {{(FrameBitsPerRow - 32){1'b0}}, s_data};
        end else begin : g_narrow
            assign dataWord = s_data[FrameBitsPerRow-1:0];
        end
    endgenerate

    // Decoders are enabled in SETUP so the registered strobe lands in STROBE
    frame_strobe_decoder #(
        .Width      (MaxFramesPerCol),
        .IndexWidth (8)
    ) u_frame_decoder (
        .en  (state == SETUP),
        .idx (frameIndex),
        .hot (frameHot)
    );

    frame_strobe_decoder #(
        .Width      (NumColumns),
        .IndexWidth (8)
    ) u_col_decoder (
        .en  (state == SETUP),
        .idx (colIndex),
        .hot (colHot)
    );

    assign s_ready = !RESET && ((state == IDLE) || (state == DATA));
    assign busy    = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            frameIndex  <= '0;
            remaining   <= '0;
            colIndex    <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            ColSelect   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            FrameStrobe <= '0;
            ColSelect   <= '0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        if (headerBad) begin
                            err <= 1'b1;
                        end else begin
                            state      <= DATA;
                            colIndex   <= hdrCol;
                            frameIndex <= hdrFrame;
                            remaining  <= hdrCount;
                        end
                    end
                end
                DATA: begin
                    if (s_valid) begin
                        FrameData <= dataWord;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    state       <= STROBE;
                    FrameStrobe <= frameHot;
                    ColSelect   <= colHot;
                end
                STROBE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    frameIndex <= frameIndex + 8'd1;
                    remaining  <= remaining - 8'd1;
                    if (remaining > 8'd1) begin
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed self-checking bench for frame_config_sequencer with default
// parameters (32-bit frames, 20 frames per column, 8 columns).
module tb_frame_config_sequencer;

    logic        CLK;
    logic        RESET;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [7:0]  ColSelect;
    logic        busy;
    logic        done;
    logic        err;

    int checkCount = 0;
    int passCount  = 0;

    frame_config_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .ColSelect   (ColSelect),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data);
        s_valid = valid;
        s_data  = data;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Strobe vectors must be one-hot-or-zero and assert together
    always @(negedge CLK) begin
        checkOutput("strobe_onehot", 64'($onehot0(FrameStrobe)), 64'd1);
        checkOutput("colsel_onehot", 64'($onehot0(ColSelect)), 64'd1);
        checkOutput("strobe_col_pair", 64'(FrameStrobe != '0), 64'(ColSelect != '0));
    end

    initial begin
        int          strobeCycle[$];
        logic [19:0] strobeVal[$];
        logic [7:0]  colVal[$];
        logic [31:0] dataVal[$];
        logic [31:0] badHeaders[4];
        logic        acc;
        int          wi;
        int          doneCount;

        RESET = 1'b1;
        applyStimulus(1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_s_ready", s_ready, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_framedata", FrameData, 32'h0);
        checkOutput("rst_strobe", FrameStrobe, 20'h0);
        checkOutput("rst_colsel", ColSelect, 8'h0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        RESET = 1'b0;
        #1;
        checkOutput("post_rst_s_ready", s_ready, 1'b1);

        $display("[TB] single frame packet");
        applyStimulus(1'b1, 32'hFA020301);
        tick();
        checkOutput("a_busy_data", busy, 1'b1);
        checkOutput("a_ready_data", s_ready, 1'b1);
        applyStimulus(1'b1, 32'hDEADBEEF);
        tick();
        checkOutput("a_setup_data", FrameData, 32'hDEADBEEF);
        checkOutput("a_setup_ready", s_ready, 1'b0);
        checkOutput("a_setup_strobe", FrameStrobe, 20'h0);
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("a_strobe", FrameStrobe, 20'h00008);
        checkOutput("a_colsel", ColSelect, 8'h04);
        checkOutput("a_strobe_data", FrameData, 32'hDEADBEEF);
        tick();
        checkOutput("a_hold_strobe", FrameStrobe, 20'h0);
        checkOutput("a_hold_done", done, 1'b0);
        checkOutput("a_hold_data", FrameData, 32'hDEADBEEF);
        tick();
        checkOutput("a_done", done, 1'b1);
        checkOutput("a_idle_busy", busy, 1'b0);
        tick();
        checkOutput("a_done_pulse", done, 1'b0);
        checkOutput("a_err", err, 1'b0);

        $display("[TB] four frame burst");
        applyStimulus(1'b1, 32'hFA000004);
        tick();
        wi = 0;
        doneCount = 0;
        applyStimulus(1'b1, 32'hA0B00000);
        for (int c = 1; c <= 24; c++) begin
            acc = s_valid && s_ready;
            tick();
            if (acc) begin
                wi++;
                if (wi < 4) applyStimulus(1'b1, 32'hA0B00000 | 32'(wi));
                else applyStimulus(1'b0, 32'h0);
            end
            if (FrameStrobe != '0) begin
                strobeCycle.push_back(c);
                strobeVal.push_back(FrameStrobe);
                colVal.push_back(ColSelect);
                dataVal.push_back(FrameData);
            end
            if (done) doneCount++;
        end
        checkOutput("b_strobe_count", 64'(strobeCycle.size()), 64'd4);
        for (int k = 0; k < strobeCycle.size() && k < 4; k++) begin
            checkOutput("b_strobe_frame", strobeVal[k], 20'h1 << k);
            checkOutput("b_colsel", colVal[k], 8'h01);
            checkOutput("b_strobe_data", dataVal[k], 32'hA0B00000 | 32'(k));
            if (k > 0) checkOutput("b_spacing", 64'(strobeCycle[k] - strobeCycle[k-1]), 64'd4);
        end
        checkOutput("b_done_count", 64'(doneCount), 64'd1);
        checkOutput("b_err", err, 1'b0);
        checkOutput("b_idle", busy, 1'b0);

        $display("[TB] invalid headers");
        badHeaders = '{32'hFB000001, 32'hFA080001, 32'hFA000000, 32'hFA001105};
        checkOutput("c_err_before", err, 1'b0);
        for (int h = 0; h < 4; h++) begin
            applyStimulus(1'b1, badHeaders[h]);
            tick();
            checkOutput("c_err", err, 1'b1);
            checkOutput("c_busy", busy, 1'b0);
            checkOutput("c_ready", s_ready, 1'b1);
            checkOutput("c_strobe", FrameStrobe, 20'h0);
        end
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("c_err_sticky", err, 1'b1);
        checkOutput("c_busy_after", busy, 1'b0);

        $display("[TB] reset during strobe");
        applyStimulus(1'b1, 32'hFA010002);
        tick();
        applyStimulus(1'b1, 32'hAAAA5555);
        tick();
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("d_strobe", FrameStrobe, 20'h00001);
        checkOutput("d_colsel", ColSelect, 8'h02);
        RESET = 1'b1;
        #1;
        checkOutput("d_rst_strobe", FrameStrobe, 20'h0);
        checkOutput("d_rst_colsel", ColSelect, 8'h0);
        checkOutput("d_rst_data", FrameData, 32'h0);
        checkOutput("d_rst_err", err, 1'b0);
        checkOutput("d_rst_busy", busy, 1'b0);
        checkOutput("d_rst_ready", s_ready, 1'b0);
        tick();
        RESET = 1'b0;
        #1;
        checkOutput("d_rel_ready", s_ready, 1'b1);
        applyStimulus(1'b1, 32'hFA070501);
        tick();
        applyStimulus(1'b1, 32'h12345678);
        tick();
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("d2_strobe", FrameStrobe, 20'h00020);
        checkOutput("d2_colsel", ColSelect, 8'h80);
        checkOutput("d2_data", FrameData, 32'h12345678);
        tick();
        tick();
        checkOutput("d2_done", done, 1'b1);
        checkOutput("d2_err", err, 1'b0);

        $display("[TB] stalled upstream");
        applyStimulus(1'b1, 32'hFA030A02);
        tick();
        applyStimulus(1'b1, 32'hCAFEF00D);
        tick();
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("e_strobe0", FrameStrobe, 20'h00400);
        checkOutput("e_colsel0", ColSelect, 8'h08);
        tick();
        tick();
        for (int w = 0; w < 10; w++) begin
            checkOutput("e_wait_data", FrameData, 32'hCAFEF00D);
            checkOutput("e_wait_strobe", FrameStrobe, 20'h0);
            checkOutput("e_wait_busy", busy, 1'b1);
            checkOutput("e_wait_ready", s_ready, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 32'h0BADC0DE);
        tick();
        applyStimulus(1'b0, 32'h0);
        checkOutput("e_new_data", FrameData, 32'h0BADC0DE);
        tick();
        checkOutput("e_strobe1", FrameStrobe, 20'h00800);
        checkOutput("e_colsel1", ColSelect, 8'h08);
        tick();
        tick();
        checkOutput("e_done", done, 1'b1);
        checkOutput("e_busy_end", busy, 1'b0);
        checkOutput("e_err", err, 1'b0);

        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/frame_config_sequencer.md
FRAME_CONFIG_SEQUENCER -- requirements
Module: frame_config_sequencer

Interface
REQ-001 Parameter FrameBitsPerRow, default 32: width of one frame data word.
REQ-002 Parameter MaxFramesPerCol, default 20: frames per column, i.e. FrameStrobe width.
REQ-003 Parameter NumColumns, default 8: number of columns, i.e. ColSelect width; must be 1..256.
REQ-004 CLK  in  1: single clock; all state updates on rising edge.
REQ-005 RESET  in  1: asynchronous, active-high reset.
REQ-006 s_valid  in  1: input word valid.
REQ-007 s_ready  out  1: sequencer accepts a word; transfer occurs when s_valid and s_ready are both high at a CLK edge.
REQ-008 s_data  in  32: header or frame data word.
REQ-009 FrameData  out  FrameBitsPerRow: frame word presented to the tile config memories.
REQ-010 FrameStrobe  out  MaxFramesPerCol: one-hot frame latch strobe.
REQ-011 ColSelect  out  NumColumns: one-hot column enable, qualifying FrameStrobe.
REQ-012 busy  out  1: high whenever state is not IDLE.
REQ-013 done  out  1: one-cycle pulse after the last frame of a packet.
REQ-014 err  out  1: sticky header error flag; cleared only by RESET.

Function
REQ-015 Packet: one header word, then N data words; header fields are [31:24] sync = 0xFA, [23:16] column C, [15:8] start frame F, [7:0] count N.
REQ-016 States: IDLE, DATA, SETUP, STROBE, HOLD.
REQ-017 s_ready shall be 1 only in IDLE and DATA.
REQ-018 IDLE, header accepted, valid -> DATA; latch C, F, N; frame index = F; remaining = N.
REQ-019 Header invalid when sync != 0xFA, C >= NumColumns, N == 0, or F+N > MaxFramesPerCol. Width rule: F+N computed at 9 bits, no wrap.
REQ-020 Invalid header: set err, discard the word, remain in IDLE. The next word is treated as a header.
REQ-021 DATA, word accepted -> SETUP; register the low FrameBitsPerRow bits of s_data into FrameData. Zero-extend if FrameBitsPerRow > 32.
REQ-022 SETUP -> STROBE unconditionally. FrameStrobe and ColSelect stay 0; FrameData is stable.
REQ-023 STROBE -> HOLD. FrameStrobe = one-hot(frame index) and ColSelect = one-hot(C) for exactly one cycle.
REQ-024 HOLD -> DATA if remaining > 1, else IDLE with done pulsed for one cycle. In both cases increment frame index, decrement remaining, and hold FrameData unchanged.
REQ-025 FrameData changes only on a DATA-state acceptance, so it is stable for one cycle before and one cycle after every strobe.
REQ-026 Minimum spacing is 4 cycles from one data acceptance to the next; s_valid low in DATA waits indefinitely.
REQ-027 FrameStrobe and ColSelect shall never be nonzero outside STROBE, and never have more than one bit set.
REQ-028 Words offered outside IDLE/DATA are not accepted (s_ready = 0), so the upstream holds them.

Reset
REQ-029 RESET asserted at any time, including mid-packet: state = IDLE and all outputs = 0 (s_ready = 0 while RESET is high; s_ready = 1 in the first cycle after release).
REQ-030 A packet interrupted by reset is abandoned; frames already strobed are not undone.

Structure
REQ-031 Package frame_config_pkg shall hold: SYNC_BYTE = 8'hFA, header field bit positions, the state enum.
REQ-032 One sub-module, frame_strobe_decoder: a combinational index-to-one-hot decoder with an enable, instantiated for FrameStrobe and again for ColSelect.
REQ-033 All outputs shall be registered except s_ready and busy, which decode from state.

Verification
REQ-034 Header 0xFA020301, then data 0xDEADBEEF -> FrameData = 0xDEADBEEF two cycles after acceptance; FrameStrobe = 1<<3 and ColSelect = 1<<2 for one cycle; done one cycle after strobe ends.
REQ-035 Header 0xFA000004, then 4 words with s_valid held high -> strobes on frames 0,1,2,3 exactly 4 cycles apart; err stays 0.
REQ-036 Headers 0xFB000001, 0xFA080001 (C=8 with NumColumns=8), 0xFA000000, 0xFA001105 (F+N=22>20) -> err = 1, no strobe, busy = 0 throughout.
REQ-037 RESET asserted while in STROBE -> all outputs 0 immediately; after release, a valid packet completes normally; err stays 0.
REQ-038 s_valid deasserted for 10 cycles mid-packet -> FrameData held, no strobes, busy = 1; packet resumes on the next valid word.
